alu_issue_ctrl: RTL and testbench

Sequencing stage that sits in front of the 32-bit ALU and collects its output. It accepts one operation at a time over a valid/ready request interface and screens the opcode against the set of implemented functions. For a legal opcode it drives the ALU opcode, operand and enable inputs for a fixed number of cycles, then registers the ALU result and returns it over a valid/ready response interface.

---
 rtl/alu_issue_ctrl.sv | 113 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/collect sequencer in front of the 32-bit ALU: screens opcodes, holds
// ALU inputs for ALU_LATENCY cycles, then returns the registered result.
module alu_issue_ctrl #(
    parameter int unsigned                WIDTH       = 32,
    parameter int unsigned                OPW         = 5,
    parameter int unsigned                ALU_LATENCY = 2,
    parameter logic [(1<<OPW)-1:0]        OP_MASK     = 32'h0000_3F00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [OPW-1:0]   alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_enable,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic [15:0]      op_count
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; valid holds its payload stable until that edge.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CYC = 4'(ALU_LATENCY - 1);

    state_t     state;
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            in_ready   <= 1'b1;
            alu_enable <= 1'b0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (OP_MASK[in_opcode]) begin
                            // The alu_* output flops double as the request latch.
                            state      <= EXEC;
                            cnt        <= '0;
                            alu_enable <= 1'b1;
                            alu_opcode <= in_opcode;
                            alu_a      <= in_a;
                            alu_b      <= in_b;
                        end else begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end
                    end
                end
                EXEC: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_CYC) begin
                        state      <= DONE;
                        rsp_data   <= alu_out;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        alu_enable <= 1'b0;
                        alu_opcode <= '0;
                        alu_a      <= '0;
                        alu_b      <= '0;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        if (!rsp_err) begin
                            op_count <= op_count + 16'd1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: vector table plus hand sequences for backpressure,
// held request, back-to-back spacing, mid-EXEC reset and op_count wrap.
module tb_alu_issue_ctrl;

    localparam int W   = 32;
    localparam int OPW = 5;
    localparam int LAT = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_opcode;
    logic [W-1:0]   in_a, in_b;
    logic [OPW-1:0] alu_opcode;
    logic [W-1:0]   alu_a, alu_b, alu_out;
    logic           alu_enable;
    logic           rsp_valid, rsp_ready, rsp_err, busy;
    logic [W-1:0]   rsp_data;
    logic [15:0]    op_count;

    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    int          last_accept = 0;
    logic [15:0] exp_cnt = '0;
    logic [W:0]  exp_q[$];

    alu_issue_ctrl #(.WIDTH(W), .OPW(OPW), .ALU_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_a(in_a), .in_b(in_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_enable(alu_enable), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // ALU stand-in: correct result while enabled, garbage otherwise.
    function automatic logic [W-1:0] alu_model(input logic [OPW-1:0] op,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            5'd8:    return a & b;
            5'd9:    return a | b;
            5'd10:   return a ^ b;
            5'd11:   return ~(a & b);
            5'd12:   return ~(a | b);
            5'd13:   return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    always_comb alu_out = alu_enable ? alu_model(alu_opcode, alu_a, alu_b) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver: one request, wait for response, optional rsp_ready stall
    task automatic run_op(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ed, input logic ee, input int hold);
        int         n;
        int         en;
        int         t;
        logic [W:0] exp;
        rsp_ready = (hold == 0);
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("accept_ready", in_ready, 1);
        in_valid    = 1'b1;
        in_opcode   = op;
        in_a        = a;
        in_b        = b;
        last_accept = cyc_cnt + 1;
        exp_q.push_back({ee, ed});
        n  = 0;
        en = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            n++;
            if (alu_enable) en++;
        end while (!rsp_valid && n < 40);
        check("rsp_latency", n, ee ? 1 : LAT + 1);
        check("enable_cycles", en, ee ? 0 : LAT);
        check("sb_nonempty", exp_q.size(), 1);
        exp = exp_q.pop_front();
        check("rsp_payload", {rsp_err, rsp_data}, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_stable", {rsp_valid, in_ready, rsp_err, rsp_data}, {1'b1, 1'b0, exp});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        if (!ee) exp_cnt = exp_cnt + 16'd1;
        check("after_handshake", {rsp_valid, in_ready, op_count}, {1'b1 ^ 1'b1, 1'b1, exp_cnt});
    endtask

    typedef struct {
        logic [OPW-1:0] op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   data;
        logic           err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int          a1;
        int          t;
        logic [W:0]  exp;
        logic [OPW-1:0] rop;
        logic [W-1:0]   ra, rb;

        vecs[0] = '{5'd8,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        vecs[1] = '{5'd0,  32'h00000001, 32'h00000002, 32'h00000000, 1'b1};
        vecs[2] = '{5'd9,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0};
        vecs[3] = '{5'd10, 32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, 1'b0};
        vecs[4] = '{5'd11, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 1'b0};
        vecs[5] = '{5'd12, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[6] = '{5'd13, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b0};
        vecs[7] = '{5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[8] = '{5'd14, 32'h11111111, 32'h22222222, 32'h00000000, 1'b1};
        vecs[9] = '{5'd7,  32'h33333333, 32'h44444444, 32'h00000000, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state",
              {in_ready, alu_enable, rsp_valid, rsp_err, busy, op_count, alu_opcode},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 5'h0});
        check("reset_data", {alu_a, alu_b, rsp_data}, 96'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // table vectors, alternating immediate and stalled responses
        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].data, vecs[i].err, (i % 3 == 2) ? 2 : 0);

        // backpressure with a second request held valid throughout
        rsp_ready = 1'b0;
        in_valid = 1'b1; in_opcode = 5'd10; in_a = 32'h12345678; in_b = 32'hFFFFFFFF;
        exp_q.push_back({1'b0, 32'hEDCBA987});
        @(negedge clk);
        in_opcode = 5'd9; in_a = 32'h0F0F0000; in_b = 32'h000000F0;
        t = 0;
        while (!rsp_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        exp = exp_q.pop_front();
        check("bp_payload", {rsp_err, rsp_data}, exp);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_stable", {rsp_valid, in_ready, alu_enable, rsp_data}, {3'b100, 32'hEDCBA987});
        end
        rsp_ready = 1'b1;
        exp_q.push_back({1'b0, 32'h0F0F00F0});
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        check("bp_idle_first", {in_ready, rsp_valid, alu_enable, op_count}, {3'b100, exp_cnt});
        @(negedge clk);
        check("bp_second_accept", {alu_enable, busy, alu_opcode}, {2'b11, 5'd9});
        in_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        exp = exp_q.pop_front();
        check("bp_second_payload", {rsp_err, rsp_data}, exp);
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        check("bp_second_count", op_count, exp_cnt);

        // back-to-back legal ops with rsp_ready high
        run_op(5'd8, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0, 0);
        a1 = last_accept;
        run_op(5'd13, 32'h0000FFFF, 32'h00FF00FF, 32'hFF0000FF, 1'b0, 0);
        check("b2b_spacing", last_accept - a1, LAT + 2);

        // random ops: legal ones through the ALU model, illegal ones outside 8..13
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 0) begin
                rop = 5'($urandom_range(8, 13));
                run_op(rop, ra, rb, alu_model(rop, ra, rb), 1'b0, int'($urandom_range(0, 2)));
            end else begin
                rop = 5'($urandom_range(14, 39) % 32);
                if (rop >= 5'd8 && rop <= 5'd13) rop = 5'd3;
                run_op(rop, ra, rb, 32'h0, 1'b1, 0);
            end
        end

        // reset during the first EXEC cycle drops the transaction
        in_valid = 1'b1; in_opcode = 5'd8; in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_in_exec", {busy, alu_enable}, 2'b11);
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        check("rst_async_outputs",
              {in_ready, alu_enable, rsp_valid, rsp_err, busy, op_count, alu_a, rsp_data},
              {5'b10000, 16'h0, 32'h0, 32'h0} );
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid || alu_enable) t++;
        end
        check("rst_no_stale_rsp", t, 0);
        run_op(5'd12, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 0);

        // op_count wrap
        @(negedge clk);
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        exp_cnt = 16'hFFFF;
        run_op(5'd8, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 0);
        check("wrap_zero", op_count, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
